// File: rtl/dmac_pkg.sv
// Shared types and sizing helpers for the DMA burst scheduler.
// Holds the FSM state enum and the derived widths BPW, W_BPW, W_LEN.
package dmac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ISSUE,
        DRAIN,
        DONE
    } dmac_state_e;

    function automatic int bpw_f(input int w_d);
        return w_d / 8;
    endfunction

    // Wide enough to hold 2**w_bnd and MAX_BURST_LEN untruncated
    function automatic int w_len_f(input int w_blen, input int w_bnd);
        return ((w_blen > w_bnd) ? w_blen : w_bnd) + 1;
    endfunction

    localparam int DMAC_W_D        = 32;
    localparam int DMAC_W_BLEN     = 8;
    localparam int DMAC_W_BOUNDARY = 12;

    localparam int BPW   = bpw_f(DMAC_W_D);
    localparam int W_BPW = $clog2(BPW);
    localparam int W_LEN = w_len_f(DMAC_W_BLEN, DMAC_W_BOUNDARY);

endpackage

// File: rtl/dmac_burst_scheduler_if.sv
// AXI address/response channels between the burst scheduler and the bus.
// master: AW/AR/bready driven, awready/arready/B/R observed. slave: reverse.
interface dmac_burst_scheduler_if #(
    parameter int W_EXT_A = 32,
    parameter int W_BLEN  = 8
);
    logic               awvalid;
    logic               awready;
    logic [W_EXT_A-1:0] awaddr;
    logic [W_BLEN-1:0]  awlen;
    logic               bvalid;
    logic               bready;
    logic               arvalid;
    logic               arready;
    logic [W_EXT_A-1:0] araddr;
    logic [W_BLEN-1:0]  arlen;
    logic               rvalid;
    logic               rready;
    logic               rlast;

    modport master (
        output awvalid, awaddr, awlen,
        input  awready,
        input  bvalid,
        output bready,
        output arvalid, araddr, arlen,
        input  arready,
        input  rvalid, rready, rlast
    );

    modport slave (
        input  awvalid, awaddr, awlen,
        output awready,
        output bvalid,
        input  bready,
        input  arvalid, araddr, arlen,
        output arready,
        output rvalid, rready, rlast
    );
endinterface

// File: rtl/dmac_burst_len_calc.sv
// Burst length = min(remaining, MAX_BURST_LEN, words to next boundary).
// Ports: cur_addr (byte, word aligned), remaining (words) -> len (beats).
module dmac_burst_len_calc
    import dmac_pkg::*;
#(
    parameter int W_D           = 32,
    parameter int W_EXT_A       = 32,
    parameter int W_BOUNDARY_A  = 12,
    parameter int W_BLEN        = 8,
    parameter int MAX_BURST_LEN = 256,
    parameter int W_SIZE        = 32
) (
    input  logic [W_EXT_A-1:0] cur_addr,
    input  logic [W_SIZE-1:0]  remaining,
    output logic [w_len_f(W_BLEN, W_BOUNDARY_A)-1:0] len
);
    localparam int NBW = $clog2(bpw_f(W_D));
    localparam int LW  = w_len_f(W_BLEN, W_BOUNDARY_A);
    localparam int CW  = (W_SIZE > LW) ? W_SIZE : LW;

    logic [LW-1:0] span;
    logic [LW-1:0] offs;
    logic [LW-1:0] to_bnd;
    logic [LW-1:0] rem_c;
    logic [CW-1:0] rem_x;

    assign span   = LW'(1) << W_BOUNDARY_A;
    assign offs   = LW'(cur_addr[W_BOUNDARY_A-1:0]);
    assign to_bnd = (span - offs) >> NBW;
    assign rem_x  = CW'(remaining);

    assign rem_c = (rem_x > CW'(MAX_BURST_LEN)) ?
                   LW'(MAX_BURST_LEN) : LW'(rem_x);

    assign len = (rem_c < to_bnd) ? rem_c : to_bnd;

endmodule

// File: rtl/dmac_burst_scheduler.sv
// Splits one DMA request into boundary-safe AXI bursts, caps bursts in
// flight and pulses done_valid when the last burst completes.
// Ports: ACLK/ARESETN, req_* command, done_* status, bus (AW/B/AR/R).
// Optional DMAC_BURST_SCHED_PERF_EN adds perf_bursts/perf_busy_cycles.
module dmac_burst_scheduler
    import dmac_pkg::*;
#(
    parameter int W_D             = 32,
    parameter int W_EXT_A         = 32,
    parameter int W_BOUNDARY_A    = 12,
    parameter int W_BLEN          = 8,
    parameter int MAX_BURST_LEN   = 256,
    parameter int W_SIZE          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [W_EXT_A-1:0] req_addr,
    input  logic [W_SIZE-1:0]  req_size,
    output logic               done_valid,
    output logic               done_write,
    dmac_burst_scheduler_if.master bus
`ifdef DMAC_BURST_SCHED_PERF_EN
    ,
    output logic [31:0]        perf_bursts,
    output logic [31:0]        perf_busy_cycles
`endif
);
    localparam int NBW = $clog2(bpw_f(W_D));
    localparam int LW  = w_len_f(W_BLEN, W_BOUNDARY_A);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

    dmac_state_e        state;
    dmac_state_e        nxt;
    logic [W_EXT_A-1:0] cur_addr;
    logic [W_SIZE-1:0]  remaining;
    logic               wr;
    logic               wr_nxt;
    logic [OW-1:0]      outst;
    logic [OW-1:0]      outst_nxt;
    logic [LW-1:0]      len;
    logic               hs;
    logic               cmp;
    logic               active;
    logic               load;

    logic               awvalid_q;
    logic               arvalid_q;
    logic [W_EXT_A-1:0] awaddr_q;
    logic [W_EXT_A-1:0] araddr_q;
    logic [W_BLEN-1:0]  awlen_q;
    logic [W_BLEN-1:0]  arlen_q;
    logic               bready_q;
    logic               req_ready_q;
    logic               done_valid_q;
    logic               done_write_q;

    dmac_burst_len_calc #(
        .W_D           (W_D),
        .W_EXT_A       (W_EXT_A),
        .W_BOUNDARY_A  (W_BOUNDARY_A),
        .W_BLEN        (W_BLEN),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .W_SIZE        (W_SIZE)
    ) u_len (
        .cur_addr  (cur_addr),
        .remaining (remaining),
        .len       (len)
    );

    assign bus.awvalid = awvalid_q;
    assign bus.awaddr  = awaddr_q;
    assign bus.awlen   = awlen_q;
    assign bus.arvalid = arvalid_q;
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = arlen_q;
    assign bus.bready  = bready_q;
    assign req_ready   = req_ready_q;
    assign done_valid  = done_valid_q;
    assign done_write  = done_write_q;

    assign active = (state != IDLE) && (state != DONE);

    assign hs = (state == ISSUE) &&
                (wr ? (awvalid_q && bus.awready)
                    : (arvalid_q && bus.arready));

    // R completions only count against a read request
    assign cmp = (bus.bvalid && bready_q) ||
                 (active && !wr && bus.rvalid &&
                  bus.rready && bus.rlast);

    // Completion at zero is dropped; issue+completion cancel out
    always_comb begin
        outst_nxt = outst;
        if (hs && !(cmp && outst != '0)) begin
            outst_nxt = outst + OW'(1);
        end else if (!hs && cmp && outst != '0) begin
            outst_nxt = outst - OW'(1);
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  if (req_valid) nxt = CALC;
            CALC: begin
                if (remaining == '0) begin
                    nxt = DRAIN;
                end else if (outst < OW'(MAX_OUTSTANDING)) begin
                    nxt = ISSUE;
                end
            end
            ISSUE: if (hs) nxt = CALC;
            DRAIN: if (outst_nxt == '0) nxt = DONE;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign wr_nxt = (state == IDLE && req_valid) ? req_write : wr;
    assign load   = (nxt == ISSUE) && (state != ISSUE);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cur_addr  <= '0;
            remaining <= '0;
            wr        <= 1'b0;
            outst     <= '0;
        end else begin
            outst <= outst_nxt;
            if (state == IDLE && req_valid) begin
                cur_addr  <= (req_addr >> NBW) << NBW;
                remaining <= req_size;
                wr        <= req_write;
            end else if (hs) begin
                cur_addr  <= cur_addr + (W_EXT_A'(len) << NBW);
                remaining <= remaining - W_SIZE'(len);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            awaddr_q     <= '0;
            araddr_q     <= '0;
            awlen_q      <= '0;
            arlen_q      <= '0;
            bready_q     <= 1'b0;
            req_ready_q  <= 1'b1;
            done_valid_q <= 1'b0;
            done_write_q <= 1'b0;
        end else begin
            awvalid_q    <= (nxt == ISSUE) && wr;
            arvalid_q    <= (nxt == ISSUE) && !wr;
            bready_q     <= wr_nxt &&
                            (nxt inside {CALC, ISSUE, DRAIN});
            req_ready_q  <= (nxt == IDLE);
            done_valid_q <= (nxt == DONE);
            done_write_q <= (nxt == DONE) && wr;
            if (load && wr) begin
                awaddr_q <= cur_addr;
                awlen_q  <= W_BLEN'(len - LW'(1));
            end
            if (load && !wr) begin
                araddr_q <= cur_addr;
                arlen_q  <= W_BLEN'(len - LW'(1));
            end
        end
    end

`ifdef DMAC_BURST_SCHED_PERF_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            perf_bursts      <= '0;
            perf_busy_cycles <= '0;
        end else begin
            if (hs) perf_bursts <= perf_bursts + 32'd1;
            if (state != IDLE) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmac_burst_scheduler.sv
// Directed bench for dmac_burst_scheduler (MAX_OUTSTANDING=2).
// Bus handshakes are logged at the falling edge and checked against constants.
module tb_dmac_burst_scheduler;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_size = '0;
    logic        done_valid;
    logic        done_write;
`ifdef DMAC_BURST_SCHED_PERF_EN
    logic [31:0] perf_bursts;
    logic [31:0] perf_busy_cycles;
`endif

    dmac_burst_scheduler_if #(.W_EXT_A(32), .W_BLEN(8)) bus ();

    dmac_burst_scheduler #(.MAX_OUTSTANDING(2)) u_dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .done_valid (done_valid),
        .done_write (done_write),
        .bus        (bus)
`ifdef DMAC_BURST_SCHED_PERF_EN
        ,
        .perf_bursts      (perf_bursts),
        .perf_busy_cycles (perf_busy_cycles)
`endif
    );

    always #5 ACLK = ~ACLK;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] aw_a[$];
    logic [31:0] ar_a[$];
    logic [7:0]  aw_l[$];
    logic [7:0]  ar_l[$];
    int          n_awv = 0;
    int          n_arv = 0;
    int          n_done = 0;
    logic        last_dw = 1'b0;

    always @(negedge ACLK) begin
        if (bus.awvalid) n_awv++;
        if (bus.arvalid) n_arv++;
        if (bus.awvalid && bus.awready) begin
            aw_a.push_back(bus.awaddr);
            aw_l.push_back(bus.awlen);
        end
        if (bus.arvalid && bus.arready) begin
            ar_a.push_back(bus.araddr);
            ar_l.push_back(bus.arlen);
        end
        if (done_valid) begin
            n_done++;
            last_dw = done_write;
        end
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_req(input logic w, input logic [31:0] a,
                          input logic [31:0] s);
        int k = 0;
        while (!req_ready && k < 50) begin
            tick();
            k++;
        end
        chk("req_ready_wait", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_size  = s;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic bpulse();
        bus.bvalid = 1'b1;
        tick();
        bus.bvalid = 1'b0;
    endtask

    task automatic rbeat();
        bus.rvalid = 1'b1;
        bus.rlast  = 1'b1;
        tick();
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
    endtask

    task automatic wait_q(input bit is_ar, input int n,
                          input string tag);
        int c = 0;
        for (int i = 0; i < 200; i++) begin
            c = is_ar ? ar_a.size() : aw_a.size();
            if (c >= n) break;
            tick();
        end
        chk(tag, 64'(c), 64'(n));
    endtask

    task automatic wait_done(input int n, input string tag);
        for (int i = 0; i < 200; i++) begin
            if (n_done >= n) break;
            tick();
        end
        chk(tag, 64'(n_done), 64'(n));
    endtask

    task automatic clr();
        aw_a.delete();
        aw_l.delete();
        ar_a.delete();
        ar_l.delete();
    endtask

    initial begin
        int d0;
        int v0;
        int k;
        bus.awready = 1'b1;
        bus.arready = 1'b1;
        bus.bvalid  = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rready  = 1'b1;
        bus.rlast   = 1'b0;
        repeat (3) tick();

        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_done_valid", 64'(done_valid), 64'd0);
        chk("rst_done_write", 64'(done_write), 64'd0);
        chk("rst_awvalid", 64'(bus.awvalid), 64'd0);
        chk("rst_arvalid", 64'(bus.arvalid), 64'd0);
        chk("rst_bready", 64'(bus.bready), 64'd0);
        chk("rst_addr", 64'(bus.awaddr | bus.araddr), 64'd0);
        chk("rst_len", 64'(bus.awlen | bus.arlen), 64'd0);
        ARESETN = 1'b1;
        tick();

        // single write burst
        clr();
        d0 = n_done;
        do_req(1'b1, 32'h1000, 32'd16);
        wait_q(1'b0, 1, "t1_aw_cnt");
        if (aw_a.size() > 0) begin
            chk("t1_awaddr", 64'(aw_a[0]), 64'h1000);
            chk("t1_awlen", 64'(aw_l[0]), 64'd15);
        end
        chk("t1_bready", 64'(bus.bready), 64'd1);
        bpulse();
        wait_done(d0 + 1, "t1_done");
        chk("t1_done_write", 64'(last_dw), 64'd1);
        tick();
        chk("t1_bready_idle", 64'(bus.bready), 64'd0);

        // read crossing a 4 KB boundary
        clr();
        d0 = n_done;
        do_req(1'b0, 32'h0FF0, 32'd8);
        wait_q(1'b1, 2, "t2_ar_cnt");
        if (ar_a.size() > 1) begin
            chk("t2_araddr0", 64'(ar_a[0]), 64'h0FF0);
            chk("t2_arlen0", 64'(ar_l[0]), 64'd3);
            chk("t2_araddr1", 64'(ar_a[1]), 64'h1000);
            chk("t2_arlen1", 64'(ar_l[1]), 64'd3);
        end
        chk("t2_bready_rd", 64'(bus.bready), 64'd0);
        bus.rvalid = 1'b1;
        tick();
        bus.rvalid = 1'b0;
        rbeat();
        repeat (3) tick();
        chk("t2_no_early_done", 64'(n_done - d0), 64'd0);
        rbeat();
        wait_done(d0 + 1, "t2_done");
        chk("t2_done_write", 64'(last_dw), 64'd0);

        // 600 words split by MAX_BURST_LEN
        clr();
        d0 = n_done;
        do_req(1'b0, 32'h0, 32'd600);
        wait_q(1'b1, 2, "t3_ar2");
        rbeat();
        wait_q(1'b1, 3, "t3_ar3");
        rbeat();
        rbeat();
        wait_done(d0 + 1, "t3_done");
        if (ar_a.size() > 2) begin
            chk("t3_araddr0", 64'(ar_a[0]), 64'h000);
            chk("t3_arlen0", 64'(ar_l[0]), 64'd255);
            chk("t3_araddr1", 64'(ar_a[1]), 64'h400);
            chk("t3_arlen1", 64'(ar_l[1]), 64'd255);
            chk("t3_araddr2", 64'(ar_a[2]), 64'h800);
            chk("t3_arlen2", 64'(ar_l[2]), 64'd87);
        end

        // outstanding cap of 2
        clr();
        d0 = n_done;
        do_req(1'b0, 32'h4000, 32'd1024);
        wait_q(1'b1, 2, "t4_ar2");
        repeat (20) tick();
        chk("t4_cap", 64'(ar_a.size()), 64'd2);
        rbeat();
        @(negedge ACLK);
        #1;
        chk("t4_third_early", 64'(ar_a.size()), 64'd2);
        @(negedge ACLK);
        #1;
        chk("t4_third_at_2", 64'(ar_a.size()), 64'd3);
        repeat (3) begin
            rbeat();
            repeat (3) tick();
        end
        wait_done(d0 + 1, "t4_done");
        chk("t4_ar_total", 64'(ar_a.size()), 64'd4);
        if (ar_a.size() > 3) begin
            chk("t4_araddr3", 64'(ar_a[3]), 64'h4C00);
            chk("t4_arlen3", 64'(ar_l[3]), 64'd255);
        end

        // zero-length request
        d0 = n_done;
        v0 = n_awv + n_arv;
        do_req(1'b0, 32'h100, 32'd0);
        k = 0;
        while (!req_ready && k < 10) begin
            tick();
            k++;
        end
        chk("t5_ready_cycles", 64'(k), 64'd3);
        tick();
        chk("t5_one_done", 64'(n_done - d0), 64'd1);
        chk("t5_no_valids", 64'(n_awv + n_arv - v0), 64'(0));

        // reset while an AW is pending
        bus.awready = 1'b0;
        do_req(1'b1, 32'h2000, 32'd4);
        k = 0;
        while (!bus.awvalid && k < 10) begin
            tick();
            k++;
        end
        chk("t6_awv_up", 64'(bus.awvalid), 64'd1);
        ARESETN = 1'b0;
        #1;
        chk("t6_rst_awvalid", 64'(bus.awvalid), 64'd0);
        chk("t6_rst_ready", 64'(req_ready), 64'd1);
        tick();
        ARESETN = 1'b1;
        bus.awready = 1'b1;
        tick();
        clr();
        d0 = n_done;
        do_req(1'b1, 32'h3000, 32'd4);
        wait_q(1'b0, 1, "t6_aw_cnt");
        if (aw_a.size() > 0) begin
            chk("t6_awaddr", 64'(aw_a[0]), 64'h3000);
            chk("t6_awlen", 64'(aw_l[0]), 64'd3);
        end
        bpulse();
        wait_done(d0 + 1, "t6_done");
        chk("t6_done_write", 64'(last_dw), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmac_burst_scheduler.md
# dmac_burst_scheduler

Splits one DMA transfer request from the control thread into AXI-compliant address bursts for the off-chip bus. Bursts never cross a 2^W_BOUNDARY_A-byte boundary and never exceed MAX_BURST_LEN beats. The block caps in-flight bursts and reports completion once every burst has finished. It sits between the control-thread command interface and the AW/AR/B/R channels that feed the DMAC IO channel data FIFOs.

## Interface
- W_D, 32: data width in bits, power of 2, ≥8; BPW = W_D/8 bytes per word
- W_EXT_A, 32: byte address width
- W_BOUNDARY_A, 12: boundary exponent (4 KB)
- W_BLEN, 8: awlen/arlen width
- MAX_BURST_LEN, 256: max beats per burst, ≤ 2^W_BLEN
- W_SIZE, 32: request length width, in words
- MAX_OUTSTANDING, 4: max bursts in flight, ≥1
- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = write (AW/B), 0 = read (AR/R)
- req_addr  in  W_EXT_A  start byte address; low log2(BPW) bits ignored, treated as 0
- req_size  in  W_SIZE  transfer length in words
- done_valid  out  1  one-cycle completion pulse
- done_write  out  1  direction of the completed request, valid with done_valid
- awvalid/awaddr/awlen  out  1/W_EXT_A/W_BLEN  write address channel; awready in 1
- bvalid  in 1; bready  out 1  write response channel
- arvalid/araddr/arlen  out  1/W_EXT_A/W_BLEN  read address channel; arready in 1
- rvalid, rready, rlast  in  1 each  monitored only; a beat completes when all three are high

## Operation
- States: IDLE, CALC, ISSUE, DRAIN, DONE.
- IDLE: req_ready=1. On req_valid, latch addr (low bits zeroed), size and direction; cur_addr=addr, remaining=size; go to CALC.
- CALC: compute len = min(remaining, MAX_BURST_LEN, to_bnd).
  - to_bnd = (2^W_BOUNDARY_A − cur_addr[W_BOUNDARY_A-1:0]) / BPW.
  - Each term uses at least max(W_BLEN, W_BOUNDARY_A) + 1 bits so that 2^W_BOUNDARY_A is not truncated.
  - If remaining==0, go to DRAIN. Otherwise, if outstanding < MAX_OUTSTANDING, go to ISSUE; else stay in CALC.
- ISSUE: assert the valid for the latched direction with addr=cur_addr and len=len−1. Hold valid, address and length stable until ready.
  - On handshake: cur_addr += len·BPW (mod 2^W_EXT_A), remaining −= len, outstanding += 1, go to CALC.
- Burst completion: write = bvalid && bready; read = rvalid && rready && rlast. Each completion decrements outstanding.
- Simultaneous issue handshake and completion in one cycle: outstanding is unchanged.
- bready = 1 whenever a write request is active (not IDLE/DONE and req_write latched), else 0.
- DRAIN: wait for outstanding==0, then go to DONE.
- DONE: done_valid=1 for exactly one cycle, then go to IDLE.
- A completion arriving while outstanding==0 is ignored; the counter saturates at 0.
- req_size==0: no bus activity, done_valid two cycles after acceptance (IDLE→CALC→DRAIN→DONE).

## Timing
- Reset values of all outputs: req_ready=1, done_valid=0, done_write=0, awvalid=0, arvalid=0, bready=0, awaddr=araddr=0, awlen=arlen=0. Internal state: IDLE, outstanding=0.
- Outputs are registered. Request accepted at edge T; first awvalid/arvalid visible in cycle T+2.
- Back-to-back bursts: next valid asserts two cycles after the previous handshake (one CALC cycle between bursts).
- done_valid is asserted in the cycle after the completion that makes outstanding 0, provided remaining==0.
- Reset asserted mid-operation: immediate return to reset values. Bursts already on the bus are abandoned; downstream must be reset together with this block.

## Configuration
- DMAC_BURST_SCHED_PERF_EN defined: adds two outputs.
  - perf_bursts [31:0]: count of address handshakes.
  - perf_busy_cycles [31:0]: count of cycles spent outside IDLE.
  - Both wrap, and both clear on reset only.
- Not defined: neither port nor their counters exist; all other behaviour is identical.

## Structure
- Shared package dmac_pkg holds:
  - the state enum (IDLE/CALC/ISSUE/DRAIN/DONE);
  - localparams BPW, W_BPW = log2(BPW), and W_LEN = max(W_BLEN, W_BOUNDARY_A) + 1.
- One combinational sub-module, dmac_burst_len_calc (cur_addr, remaining → len), so the boundary arithmetic can be unit-tested alone.

## Test plan
(W_D=32, W_BOUNDARY_A=12, MAX_BURST_LEN=256 unless stated.)
- Write, addr 0x1000, size 16 → one AW: awaddr=0x1000, awlen=15, bready=1. One bvalid → done_valid with done_write=1.
- Read, addr 0x0FF0, size 8 → AR 0x0FF0 len 3, then AR 0x1000 len 3. done_valid after the second rlast beat.
- Read, addr 0x0, size 600 → ARs at 0x000/0x400/0x800 with arlen 255/255/87.
- MAX_OUTSTANDING=2, arready=1, no rlast, size 1024 → exactly 2 ARs. The third AR is issued 2 cycles after the first rlast beat.
- size 0 → req_ready back to 1 within 3 cycles, one done_valid, zero aw/ar valids.
- Reset during ISSUE with awvalid=1 → awvalid=0 and req_ready=1 immediately. A fresh write request then completes normally.
